mul_sched: RTL
==============

Name: mul_sched

Overview:
- Scheduler/arbiter that shares one iterative 24x24 shift-add multiply + popcount datapath between two requesters.
- Requester 0 is the bus register front-end (A1/A2 write, W/L/B readback).
- Requester 1 is the GPIO-latch trigger path.
- Grants round-robin, captures operands at grant, sequences the multiply and ones count with fixed latency, and returns tagged results on a shared response bus.

Parameters:
- A_W, 24, operand width (A1, A2)
- W_W, 32, result width returned as W
- CNT_W, 16, width of completed-operation counter

Ports:
- clk  in  1  clock, all logic on rising edge
- n_reset  in  1  reset, asynchronous, active-low
- req0  in  1  requester 0 job request, held until ack0
- a1_0  in  A_W  requester 0 first operand
- a2_0  in  A_W  requester 0 second operand
- ack0  out  1  one-cycle pulse: req0 granted, operands captured
- req1  in  1  requester 1 job request, held until ack1
- a1_1  in  A_W  requester 1 first operand
- a2_1  in  A_W  requester 1 second operand
- ack1  out  1  one-cycle pulse: req1 granted, operands captured
- resp_valid  out  1  one-cycle pulse: result fields valid
- resp_id  out  1  requester that owns the response
- resp_w  out  W_W  product[31:0]
- resp_ovf  out  1  product[47:32] != 0
- resp_ones  out  6  popcount(product[31:0]), range 0..32
- busy  out  1  job in flight
- op_count  out  CNT_W  completed jobs, wraps

Behaviour:
- Reset (async, n_reset=0): all outputs 0; state IDLE; accumulator, operand and count registers 0; last_grant=1, so requester 0 wins the first tie.
- FSM states: IDLE, MULT, COUNT, RESP.
- IDLE
  - If any req is high, grant one requester.
  - Capture its a1/a2 into internal regs, pulse its ack for that cycle (cycle T), set busy, clear the 48-bit accumulator, go to MULT.
  - If no req, stay in IDLE.
- Arbitration:
  - Only one req high: grant it.
  - Both high: grant !last_grant.
  - Update last_grant on every grant.
- MULT: 24 cycles, T+1..T+24. Cycle k (k=0..23) does acc += (a2_reg[k] ? {24'b0,a1_reg}<<k : 0). No early exit; latency is fixed regardless of operands.
- COUNT (T+25): compute ones = popcount(acc[31:0]) and ovf = |acc[47:32]; register both.
- RESP (T+26)
  - resp_valid=1 and resp_id = granted requester.
  - resp_w/ovf/ones driven from registers.
  - op_count += 1, wrapping 0xFFFF -> 0x0000.
  - Next state IDLE; busy drops at T+27. Earliest next ack is T+27.
- Result fields hold their last values after resp_valid falls and are read only when resp_valid=1.
- busy is high from cycle T through T+26 inclusive.
- req held low before grant: no job. req dropped after ack: ignored, job completes.
- req held high after ack: treated as a new job and granted again only when FSM returns to IDLE, subject to round-robin.
- Operand inputs change during a job: no effect, since captured regs are used.
- Reset mid-job (any state): job discarded, no resp_valid, op_count cleared, arbitration pointer reset.
- Zero operand(s): W=0, ones=0, ovf=0, still full 27-cycle latency.
- No combinational path from req to resp; ack is registered-state-based (Moore in IDLE plus req decode).

Decomposition:
- Package mul_sched_pkg holds:
  - A_W, W_W, CNT_W, and PROD_W = 2*A_W
  - the FSM state enum {IDLE, MULT, COUNT, RESP}
  - MULT_CYCLES=24
  - popcount32 function
- Sub-module mul_shift_core holds the operand regs, 48-bit accumulator and 5-bit bit-index counter.
  - Interface: start/load, a1, a2 in; done, product out.
  - mul_sched keeps arbitration, FSM, response regs and op_count.

Test Plan:
- Reset -> all outputs 0, busy=0, op_count=0; release reset with no req -> FSM idle, no ack for 50 cycles.
- req0 with a1_0=3, a2_0=5 -> ack0 at T, resp_valid at exactly T+26 with id=0, W=0x0000000F, ones=4, ovf=0, op_count=1.
- req1 with a1_1=a2_1=0xFFFFFF -> product 0xFFFFFE000001; resp id=1, W=0xFE000001, ovf=1, ones=8.
- req0 and req1 both held high from reset release
  - ack0 at T, ack1 at T+27.
  - Responses ordered id 0, 1, 0, 1...
  - Operands a1=0x000100, a2=0x000100 give W=0x00010000, ones=1, ovf=0.
- Start a job, assert n_reset=0 at T+10 -> no resp_valid, busy=0, op_count=0 immediately; after release, req0 and req1 both high -> requester 0 granted first.
- Force op_count to 0xFFFF, run one job with a1=0, a2=0x123456 -> W=0, ones=0, ovf=0, op_count wraps to 0x0000.

Source files
------------

// File: rtl/mul_sched_pkg.sv
// Shared widths, FSM encoding and helpers for the shared multiply/popcount scheduler.
package mul_sched_pkg;
    localparam int A_W         = 24;
    localparam int W_W         = 32;
    localparam int CNT_W       = 16;
    localparam int PROD_W      = 2 * A_W;
    localparam int MULT_CYCLES = 24;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MULT  = 2'd1,
        COUNT = 2'd2,
        RESP  = 2'd3
    } state_t;

    function automatic logic [5:0] popcount32(input logic [31:0] v);
        logic [5:0] c;
        c = '0;
        for (int i = 0; i < 32; i++) c = c + {5'b0, v[i]};
        return c;
    endfunction
endpackage

// File: rtl/mul_shift_core.sv
// Iterative 24x24 shift-add multiplier: one multiplier bit per cycle, fixed 24-cycle latency.
module mul_shift_core
    import mul_sched_pkg::*;
(
    input  logic              clk,
    input  logic              n_reset,
    input  logic              start,
    input  logic [A_W-1:0]    a1,
    input  logic [A_W-1:0]    a2,
    output logic              done,
    output logic [PROD_W-1:0] product
);
    logic [A_W-1:0]    a1_q, a2_q;
    logic [PROD_W-1:0] acc;
    logic [4:0]        idx;
    logic              run;

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            a1_q <= '0;
            a2_q <= '0;
            acc  <= '0;
            idx  <= '0;
            run  <= 1'b0;
        end else if (start) begin
            a1_q <= a1;
            a2_q <= a2;
            acc  <= '0;
            idx  <= '0;
            run  <= 1'b1;
        end else if (run) begin
            // No early exit on zero multiplier bits: latency must not depend on operands.
            if (a2_q[idx]) acc <= acc + ({{A_W{1'b0}}, a1_q} << idx);
            idx <= idx + 5'd1;
            if (done) run <= 1'b0;
        end
    end

    assign done    = run && (idx == 5'(MULT_CYCLES - 1));
    assign product = acc;
endmodule

// File: rtl/mul_sched.sv
// Round-robin scheduler sharing one multiply + ones-count datapath between two requesters.
module mul_sched
    import mul_sched_pkg::*;
(
    input  logic             clk,
    input  logic             n_reset,
    input  logic             req0,
    input  logic [A_W-1:0]   a1_0,
    input  logic [A_W-1:0]   a2_0,
    output logic             ack0,
    input  logic             req1,
    input  logic [A_W-1:0]   a1_1,
    input  logic [A_W-1:0]   a2_1,
    output logic             ack1,
    output logic             resp_valid,
    output logic             resp_id,
    output logic [W_W-1:0]   resp_w,
    output logic             resp_ovf,
    output logic [5:0]       resp_ones,
    output logic             busy,
    output logic [CNT_W-1:0] op_count
);
    state_t            state, next;
    logic              last_grant, cur_id;
    logic              grant0, grant1, start, done;
    logic [CNT_W-1:0]  cnt_q;
    logic [PROD_W-1:0] product;

    // Tie goes to the requester that was not served last.
    assign grant0 = req0 && (!req1 || last_grant);
    assign grant1 = req1 && (!req0 || !last_grant);

    always_comb begin
        next  = state;
        start = 1'b0;
        case (state)
            IDLE: begin
                if (grant0 || grant1) begin
                    start = 1'b1;
                    next  = MULT;
                end
            end
            MULT:    if (done) next = COUNT;
            COUNT:   next = RESP;
            RESP:    next = IDLE;
            default: next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            cur_id     <= 1'b0;
            resp_id    <= 1'b0;
            resp_w     <= '0;
            resp_ovf   <= 1'b0;
            resp_ones  <= '0;
            cnt_q      <= '0;
        end else begin
            state <= next;
            if (start) begin
                last_grant <= grant1;
                cur_id     <= grant1;
            end
            // Results and count land together so they are coherent in the RESP cycle.
            if (state == COUNT) begin
                resp_w    <= product[W_W-1:0];
                resp_ones <= popcount32(product[31:0]);
                resp_ovf  <= |product[PROD_W-1:32];
                resp_id   <= cur_id;
                cnt_q     <= cnt_q + 1'b1;
            end
        end
    end

    mul_shift_core u_core (
        .clk     (clk),
        .n_reset (n_reset),
        .start   (start),
        .a1      (grant1 ? a1_1 : a1_0),
        .a2      (grant1 ? a2_1 : a2_0),
        .done    (done),
        .product (product)
    );

    assign ack0       = start && grant0;
    assign ack1       = start && grant1;
    assign busy       = (state != IDLE) || start;
    assign resp_valid = (state == RESP);
    assign op_count   = cnt_q;
endmodule
